bcd_serial_add_ctrl: RTL and testbench

Sequencing controller that computes a multi-digit packed-BCD sum with a single 4-bit BCD digit adder, one digit per clock, least-significant digit first. It holds operand and result shift registers, carries the decimal carry between digits, rejects non-BCD operands, and reports completion with a start/busy/done handshake. It sits between a host (keypad/register front end) and the display path wherever a full-width parallel BCD adder costs too much area.

---
 rtl/bcd_pkg.sv | 17 +
 rtl/bcd_serial_add_ctrl_if.sv | 26 ++
 rtl/bcd_digit_slice.sv | 25 ++
 rtl/bcd_serial_add_ctrl.sv | 116 +++++++++++
 tb/tb_bcd_serial_add_ctrl.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the serial BCD adder: FSM encoding and decimal constants.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_CORR = 4'd6;

  function automatic logic is_bcd_digit(input logic [3:0] digit);
    return digit <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_serial_add_ctrl_if.sv
// Host-side handshake and operand/result bus for the serial BCD adder.
interface bcd_serial_add_ctrl_if #(
  parameter int DIGITS = 4
);

  logic                  start;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  cin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   sum;
  logic                  cout;
  logic                  err;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, err
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, err
  );

endinterface

// File: rtl/bcd_digit_slice.sv
// Combinational single-digit BCD adder: binary add, then +6 correction when the raw sum exceeds 9.
module bcd_digit_slice
  import bcd_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] d,
  output logic       co
);

  logic [4:0] raw;

  always_comb begin
    raw = {1'b0, a} + {1'b0, b} + {4'b0, ci};
    d   = raw[3:0];
    co  = 1'b0;
    // Raw sums 10..19 wrap into the next decade; the +6 skips the six unused codes.
    if (raw > {1'b0, BCD_MAX}) begin
      d  = raw[3:0] + BCD_CORR;
      co = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Multi-digit packed-BCD adder reusing one digit slice, LSD first, with start/busy/done handshake.
module bcd_serial_add_ctrl
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bcd_serial_add_ctrl_if.slave  bus
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t          state;
  state_t          next_state;
  logic [W-1:0]    a_sh;
  logic [W-1:0]    b_sh;
  logic [W-1:0]    sum_sh;
  logic [W+3:0]    sum_ins;
  logic            carry;
  logic            cout_r;
  logic            err_r;
  logic [CW-1:0]   cnt;
  logic            last_digit;
  logic            operands_ok;
  logic [3:0]      slice_d;
  logic            slice_co;

  bcd_digit_slice u_slice (
    .a  (a_sh[3:0]),
    .b  (b_sh[3:0]),
    .ci (carry),
    .d  (slice_d),
    .co (slice_co)
  );

  assign last_digit = (cnt == CW'(DIGITS - 1));
  assign sum_ins    = {slice_d, sum_sh};

  always_comb begin
    operands_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!is_bcd_digit(bus.a[4*i +: 4]) || !is_bcd_digit(bus.b[4*i +: 4])) begin
        operands_ok = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (bus.start) next_state = operands_ok ? ADD : DONE;
      ADD:  if (last_digit) next_state = DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state == ADD);
    bus.done = (state == DONE);
  end

  // An invalid operand skips ADD entirely, so the zeroed sum loaded here is the final result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      err_r  <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh   <= bus.a;
            b_sh   <= bus.b;
            sum_sh <= '0;
            carry  <= bus.cin;
            cout_r <= 1'b0;
            err_r  <= ~operands_ok;
            cnt    <= '0;
          end
        end
        ADD: begin
          a_sh   <= a_sh >> 4;
          b_sh   <= b_sh >> 4;
          sum_sh <= sum_ins[W+3:4];
          carry  <= slice_co;
          if (last_digit) begin
            cout_r <= slice_co;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sum  = sum_sh;
  assign bus.cout = cout_r;
  assign bus.err  = err_r;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Scoreboard bench for bcd_serial_add_ctrl: decimal reference model, randomized and directed operands.
module tb_bcd_serial_add_ctrl;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         err;
    int           done_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  bcd_serial_add_ctrl_if #(.DIGITS(DIGITS)) bus ();

  bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t         sb[$];
  exp_t         mon_e;
  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  int           busy_lo = 1;
  int           busy_hi = 0;
  logic [W-1:0] last_sum = '0;
  logic         last_cout = 1'b0;
  logic         last_err = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic bit has_bad(input logic [W-1:0] x);
    bit bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) if (x[4*i +: 4] > 4'd9) bad = 1'b1;
    return bad;
  endfunction

  function automatic longint bcd2int(input logic [W-1:0] x);
    longint v = 0;
    longint p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      v += longint'(x[4*i +: 4]) * p;
      p *= 10;
    end
    return v;
  endfunction

  function automatic logic [W-1:0] int2bcd(input longint v);
    logic [W-1:0] r = '0;
    longint t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rand_bcd(input bit allow_bad);
    logic [W-1:0] r = '0;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    if (allow_bad && ($urandom_range(0, 7) == 0)) begin
      r[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Monitor: busy window every cycle, scoreboard pop on done, held results while idle.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("busy", 32'(bus.busy), 32'(cyc >= busy_lo && cyc <= busy_hi));
      if (bus.done) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_done", 32'(bus.done), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          checkOutput("done_cycle", 32'(cyc), 32'(mon_e.done_cyc));
          checkOutput("sum", 32'(bus.sum), 32'(mon_e.sum));
          checkOutput("cout", 32'(bus.cout), 32'(mon_e.cout));
          checkOutput("err", 32'(bus.err), 32'(mon_e.err));
          last_sum  = mon_e.sum;
          last_cout = mon_e.cout;
          last_err  = mon_e.err;
        end
      end else if (!bus.busy) begin
        checkOutput("hold_sum", 32'(bus.sum), 32'(last_sum));
        checkOutput("hold_cout", 32'(bus.cout), 32'(last_cout));
        checkOutput("hold_err", 32'(bus.err), 32'(last_err));
      end
    end
  end

  // Called at a negedge; returns at the negedge of the first IDLE cycle after the operation.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic cin, input bit hold);
    exp_t   e;
    longint s;
    longint lim = 1;
    int     t;
    for (int i = 0; i < DIGITS; i++) lim *= 10;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
    bus.start = 1'b1;
    t = cyc + 1;
    if (has_bad(a) || has_bad(b)) begin
      e.sum      = '0;
      e.cout     = 1'b0;
      e.err      = 1'b1;
      e.done_cyc = t;
    end else begin
      s          = bcd2int(a) + bcd2int(b) + longint'(cin);
      e.cout     = (s >= lim);
      e.sum      = int2bcd(s % lim);
      e.err      = 1'b0;
      e.done_cyc = t + DIGITS;
      busy_lo    = t;
      busy_hi    = t + DIGITS - 1;
    end
    sb.push_back(e);
    repeat (e.done_cyc - t + 1) begin
      @(negedge clk);
      if (hold) begin
        bus.start = 1'b1;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        bus.cin   = 1'($urandom);
      end else begin
        bus.start = 1'b0;
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  initial begin
    int t;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("reset_done", 32'(bus.done), 32'd0);
    checkOutput("reset_sum", 32'(bus.sum), 32'd0);
    checkOutput("reset_cout", 32'(bus.cout), 32'd0);
    checkOutput("reset_err", 32'(bus.err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(16'h1234, 16'h5678, 1'b0, 1'b0);
    applyStimulus(16'h9999, 16'h0001, 1'b0, 1'b0);
    applyStimulus(16'h9999, 16'h9999, 1'b1, 1'b0);
    applyStimulus(16'h0000, 16'h0000, 1'b1, 1'b0);
    applyStimulus(16'h12A4, 16'h0001, 1'b0, 1'b0);
    applyStimulus(16'h1234, 16'h5678, 1'b1, 1'b1);
    applyStimulus(16'h0F00, 16'h1111, 1'b0, 1'b1);

    // Reset lands two edges into an ADD: no done, outputs cleared.
    bus.a     = 16'h1234;
    bus.b     = 16'h4321;
    bus.cin   = 1'b0;
    bus.start = 1'b1;
    t = cyc + 1;
    busy_lo = t;
    busy_hi = t + 1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", 32'(bus.busy), 32'd0);
    checkOutput("abort_done", 32'(bus.done), 32'd0);
    checkOutput("abort_sum", 32'(bus.sum), 32'd0);
    checkOutput("abort_cout", 32'(bus.cout), 32'd0);
    checkOutput("abort_err", 32'(bus.err), 32'd0);
    last_sum  = '0;
    last_cout = 1'b0;
    last_err  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(16'h0500, 16'h0500, 1'b0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      applyStimulus(rand_bcd(1'b1), rand_bcd(1'b1), 1'($urandom), bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
